load_store_unit: RTL and testbench

Multi-cycle load/store controller between the EX/MEM pipeline register and a word-organised data memory with a req/ack handshake of variable latency. It converts a byte address plus func3 into a word address, byte enables and lane-replicated write data. It sign- or zero-extends returned load data and stalls the pipeline until the access completes. It flags misaligned or illegal accesses and bus timeouts instead of performing them.

---
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store controller between the EX/MEM register and a req/ack word memory.
// Generates word address, byte lanes and replicated store data; extends load results.
module load_store_unit #(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            func3,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  mem_stall,
   output logic                  access_err,
   output logic                  bus_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DM_ADDRESS-3:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [2:0]            f3_q, f3_d;
   logic [1:0]            lane_q, lane_d;
   logic [DM_ADDRESS-3:0] maddr_q, maddr_d;
   logic [3:0]            be_q, be_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  req_q, req_d;
   logic [DATA_W-1:0]     rd_q, rd_d;
   logic                  berr_q, berr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic              active, legal_f3, aligned, valid;
   logic [3:0]        be_new;
   logic [DATA_W-1:0] wdata_new;
   logic [7:0]        ld_b;
   logic [15:0]       ld_h;
   logic [DATA_W-1:0] ld_ext;

   // Access decode; a store takes priority when both requests are raised.
   always_comb begin
      active   = MemRead | MemWrite;
      legal_f3 = 1'b0;
      aligned  = 1'b0;
      if (MemWrite) begin
         legal_f3 = (func3 == 3'b000) | (func3 == 3'b001) | (func3 == 3'b010);
      end else begin
         legal_f3 = (func3 == 3'b000) | (func3 == 3'b001) | (func3 == 3'b010) |
                    (func3 == 3'b100) | (func3 == 3'b101);
      end
      case (func3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~addr[0];
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
      valid = active & legal_f3 & aligned;
   end

   always_comb begin
      be_new    = 4'b1111;
      wdata_new = wr_data;
      if (MemWrite) begin
         case (func3[1:0])
            2'b00: begin
               be_new    = 4'b0001 << addr[1:0];
               wdata_new = {4{wr_data[7:0]}};
            end
            2'b01: begin
               be_new    = addr[1] ? 4'b1100 : 4'b0011;
               wdata_new = {2{wr_data[15:0]}};
            end
            default: begin
               be_new    = 4'b1111;
               wdata_new = wr_data;
            end
         endcase
      end
   end

   always_comb begin
      ld_b = 8'h00;
      case (lane_q)
         2'd0:    ld_b = mem_rdata[7:0];
         2'd1:    ld_b = mem_rdata[15:8];
         2'd2:    ld_b = mem_rdata[23:16];
         default: ld_b = mem_rdata[31:24];
      endcase
      ld_h = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
         3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
         3'b100:  ld_ext = {24'h000000, ld_b};
         3'b101:  ld_ext = {16'h0000, ld_h};
         default: ld_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      lane_d  = lane_q;
      maddr_d = maddr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      req_d   = req_q;
      rd_d    = rd_q;
      berr_d  = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (valid) begin
               we_d    = MemWrite;
               f3_d    = func3;
               lane_d  = addr[1:0];
               maddr_d = addr[DM_ADDRESS-1:2];
               be_d    = be_new;
               wdata_d = wdata_new;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            // Ack on the last allowed cycle still completes normally.
            if (mem_ack) begin
               req_d   = 1'b0;
               state_d = DONE;
               if (!we_q) rd_d = ld_ext;
            end else if (cnt_q == CNT_LAST) begin
               req_d   = 1'b0;
               berr_d  = 1'b1;
               state_d = DONE;
               if (!we_q) rd_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         lane_q  <= '0;
         maddr_q <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         req_q   <= 1'b0;
         rd_q    <= '0;
         berr_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         lane_q  <= lane_d;
         maddr_q <= maddr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         req_q   <= req_d;
         rd_q    <= rd_d;
         berr_q  <= berr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_stall  = reset & (((state_q == IDLE) & valid) | (state_q == REQ));
   assign access_err = reset & (state_q == IDLE) & active & ~valid;
   assign rd_data    = rd_q;
   assign bus_err    = berr_q;
   assign mem_req    = req_q;
   assign mem_we     = we_q;
   assign mem_addr   = maddr_q;
   assign mem_be     = be_q;
   assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [2:0]  func3;
   logic [8:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        mem_stall, access_err, bus_err, mem_req, mem_we;
   logic [6:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.DATA_W(32), .DM_ADDRESS(9), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .func3(func3), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
      .mem_stall(mem_stall), .access_err(access_err), .bus_err(bus_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   typedef struct {
      bit          err;
      bit          we;
      logic [6:0]  maddr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rd;
      bit          berr;
      int          n_req;
   } exp_t;

   exp_t        q[$];
   exp_t        me;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  bmem [512];
   logic [31:0] model_rd;
   int          cur_lat = 1;
   bit          prev_req = 0;
   int          req_cnt = 0;
   int          rcnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic bit legal_acc(bit wr, logic [2:0] f3, logic [8:0] a);
      bit ok;
      int sz;
      if (wr) ok = (f3 == 0) || (f3 == 1) || (f3 == 2);
      else    ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      sz = 1 << f3[1:0];
      return ok && ((int'(a) % sz) == 0);
   endfunction

   // lat: REQ cycle on which memory acks; 0 = never ack.
   task automatic issue(bit rd, bit wr, logic [2:0] f3, logic [8:0] a, logic [31:0] wd, int lat);
      exp_t   e;
      int     sz;
      longint v;
      bit     fin;
      if (rd || wr) begin
         e = '{default: 0};
         if (!legal_acc(wr, f3, a)) begin
            e.err = 1;
            e.rd  = model_rd;
         end else begin
            sz      = 1 << f3[1:0];
            e.we    = wr;
            e.maddr = a[8:2];
            e.n_req = (lat == 0) ? TMO : lat;
            e.berr  = (lat == 0);
            if (wr) begin
               e.be    = 4'(((1 << sz) - 1) << (int'(a) % 4));
               e.wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
               if (lat != 0)
                  for (int i = 0; i < sz; i++) bmem[int'(a) + i] = wd[8*i +: 8];
            end else begin
               e.be = 4'hF;
               if (lat == 0) model_rd = '0;
               else begin
                  v = 0;
                  for (int i = 0; i < sz; i++) v += longint'(bmem[int'(a) + i]) << (8 * i);
                  if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
                     v -= longint'(1) << (8 * sz);
                  model_rd = 32'(v);
               end
            end
            e.rd = model_rd;
         end
         q.push_back(e);
      end
      cur_lat = lat;
      @(posedge clk); #1;
      MemRead = rd; MemWrite = wr; func3 = f3; addr = a; wr_data = wd;
      fin = 0;
      for (int k = 0; k < TMO + 4 && !fin; k++) begin
         @(negedge clk);
         if (!mem_stall) fin = 1;
      end
      chk("stall_release", 32'(fin), 1);
   endtask

   // Memory responder: acks on the programmed REQ cycle, noise elsewhere.
   always @(negedge clk) begin
      if (mem_req && reset) begin
         rcnt++;
         if (cur_lat != 0 && rcnt == cur_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = {bmem[{mem_addr, 2'd3}], bmem[{mem_addr, 2'd2}],
                         bmem[{mem_addr, 2'd1}], bmem[{mem_addr, 2'd0}]};
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
         end
      end else begin
         rcnt      = 0;
         mem_ack   = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
      end
   end

   // Monitor: checks requests each REQ cycle, results on completion or access error.
   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_req", 32'(mem_req), 0);
         chk("rst_stall", 32'(mem_stall), 0);
         chk("rst_access_err", 32'(access_err), 0);
         chk("rst_rd_data", rd_data, 0);
         chk("rst_bus_err", 32'(bus_err), 0);
         prev_req = 0;
         req_cnt  = 0;
      end else if (mem_req) begin
         chk("req_expected", 32'(q.size() != 0), 1);
         if (q.size() != 0) begin
            me = q[0];
            chk("req_kind_err", 32'(me.err), 0);
            chk("req_we", 32'(mem_we), 32'(me.we));
            chk("req_addr", 32'(mem_addr), 32'(me.maddr));
            chk("req_be", 32'(mem_be), 32'(me.be));
            if (me.we) chk("req_wdata", mem_wdata, me.wdata);
            chk("req_stall", 32'(mem_stall), 1);
         end
         chk("req_bus_err", 32'(bus_err), 0);
         req_cnt++;
         prev_req = 1;
      end else if (prev_req) begin
         chk("done_expected", 32'(q.size() != 0), 1);
         if (q.size() != 0) begin
            me = q.pop_front();
            chk("done_rd_data", rd_data, me.rd);
            chk("done_bus_err", 32'(bus_err), 32'(me.berr));
            chk("done_req_cycles", 32'(req_cnt), 32'(me.n_req));
         end
         chk("done_stall", 32'(mem_stall), 0);
         chk("done_access_err", 32'(access_err), 0);
         prev_req = 0;
         req_cnt  = 0;
      end else begin
         chk("idle_bus_err", 32'(bus_err), 0);
         if (access_err) begin
            chk("aerr_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
               me = q.pop_front();
               chk("aerr_kind", 32'(me.err), 1);
               chk("aerr_rd_data", rd_data, me.rd);
            end
            chk("aerr_stall", 32'(mem_stall), 0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          r, w;
      int          sel;
      logic [2:0]  f3;
      logic [8:0]  a;
      int          lat;
      logic [2:0]  legal_list [5];

      legal_list[0] = 3'd0; legal_list[1] = 3'd1; legal_list[2] = 3'd2;
      legal_list[3] = 3'd4; legal_list[4] = 3'd5;
      reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; func3 = 3'd2; addr = 9'h010;
      wr_data = '0; model_rd = '0;
      for (int i = 0; i < 512; i++) bmem[i] = 8'($urandom);
      repeat (2) @(negedge clk);
      MemRead = 1'b0;
      @(posedge clk); #1 reset = 1'b1;

      bmem[9'h010] = 8'hEF; bmem[9'h011] = 8'hBE; bmem[9'h012] = 8'hAD; bmem[9'h013] = 8'hDE;
      issue(1, 0, 3'd2, 9'h010, 0, 1);
      bmem[9'h010] = 8'h34; bmem[9'h011] = 8'h12; bmem[9'h012] = 8'hFF; bmem[9'h013] = 8'h80;
      issue(1, 0, 3'd0, 9'h013, 0, 1);
      issue(1, 0, 3'd4, 9'h013, 0, 1);
      issue(0, 1, 3'd1, 9'h006, 32'h0000ABCD, 3);
      issue(1, 0, 3'd2, 9'h011, 0, 1);
      issue(1, 0, 3'd3, 9'h010, 0, 1);
      issue(0, 1, 3'd4, 9'h010, 32'h12345678, 1);
      issue(1, 0, 3'd2, 9'h040, 0, 0);
      issue(1, 0, 3'd2, 9'h044, 0, TMO);
      issue(0, 1, 3'd2, 9'h048, 32'hCAFEF00D, 0);
      issue(1, 0, 3'd2, 9'h048, 0, 2);

      for (int n = 0; n < 250; n++) begin
         sel = $urandom_range(0, 9);
         r = (sel >= 1 && sel <= 5) || sel == 9;
         w = (sel >= 6);
         f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : legal_list[$urandom_range(0, 4)];
         a = 9'($urandom);
         if ($urandom_range(0, 3) != 0) a = a & ~9'((1 << f3[1:0]) - 1);
         sel = $urandom_range(0, 19);
         lat = (sel == 0) ? 0 : (sel == 1) ? TMO : $urandom_range(1, 4);
         issue(r, w, f3, a, $urandom, lat);
      end

      // Abandon a pending load by resetting in its second REQ cycle.
      issue(1, 0, 3'd2, 9'h050, 0, 1);
      q.push_back('{err: 0, we: 0, maddr: 7'h14, be: 4'hF, wdata: '0, rd: '0, berr: 1, n_req: TMO});
      cur_lat = 0;
      @(posedge clk); #1 MemRead = 1'b1; MemWrite = 1'b0; func3 = 3'd2; addr = 9'h050;
      @(posedge clk); #1;
      @(posedge clk); #1 reset = 1'b0;
      q.delete();
      model_rd = '0;
      #1;
      chk("midreq_reset_req", 32'(mem_req), 0);
      chk("midreq_reset_rd", rd_data, 0);
      MemRead = 1'b0;
      @(posedge clk); #1 reset = 1'b1;

      issue(0, 1, 3'd2, 9'h020, 32'h13579BDF, 2);
      issue(1, 0, 3'd2, 9'h020, 0, 1);
      issue(1, 0, 3'd5, 9'h022, 0, 1);
      repeat (3) issue(0, 0, 3'd0, 9'h000, 0, 1);
      chk("queue_drained", 32'(q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
